writeback_arbiter: RTL and testbench

- Write-side front end of the register file. It merges two result sources onto the single regfile write port (write enable, rd index, write data):
  - the in-order pipeline WB slot;
  - a long-latency unit (LU: mul/div, load-miss) through a valid/ready handshake.
- Keeps a pending-register scoreboard for LU destinations and raises a read-hazard stall for decode.
- Buffers up to 2 LU results and guarantees them forward progress against pipeline traffic.

---
 rtl/writeback_arbiter_if.sv | 40 ++++
 rtl/writeback_arbiter.sv | 120 ++++++++++++
 tb/tb_writeback_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Bundle of the regfile write-side signals: pipeline WB slot, LU issue/response,
// decode source indices, stall outputs and the single regfile write port.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pipe_wb_valid;
  logic [4:0]            pipe_wb_rd;
  logic [DATA_WIDTH-1:0] pipe_wb_data;
  logic                  lu_issue_valid;
  logic [4:0]            lu_issue_rd;
  logic                  lu_resp_valid;
  logic                  lu_resp_ready;
  logic [4:0]            lu_resp_rd;
  logic [DATA_WIDTH-1:0] lu_resp_data;
  logic [4:0]            rs1_index;
  logic [4:0]            rs2_index;
  logic                  hazard_stall;
  logic                  pipe_stall;
  logic                  rf_write_enable;
  logic [4:0]            rf_rd_index;
  logic [DATA_WIDTH-1:0] rf_write_data;

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output lu_issue_valid, lu_issue_rd,
    output lu_resp_valid, lu_resp_rd, lu_resp_data,
    output rs1_index, rs2_index,
    input  lu_resp_ready, hazard_stall, pipe_stall,
    input  rf_write_enable, rf_rd_index, rf_write_data
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  lu_issue_valid, lu_issue_rd,
    input  lu_resp_valid, lu_resp_rd, lu_resp_data,
    input  rs1_index, rs2_index,
    output lu_resp_ready, hazard_stall, pipe_stall,
    output rf_write_enable, rf_rd_index, rf_write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges pipeline WB results and buffered long-latency results onto the single
// regfile write port; tracks pending LU destinations for decode hazard stalls.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_arbiter_if.slave   bus
);

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  entry_t      fifo_q [2];
  entry_t      fifo_d [2];
  logic [1:0]  count_q, count_d;
  logic [3:0]  age_q, age_d;
  logic [31:0] pending_q, pending_d;

  logic                  head_valid;
  logic                  pop;
  logic                  push;
  logic                  stall;
  logic                  ready;
  logic                  haz;
  logic                  we;
  logic [4:0]            idx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           pending_eff;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the branches below can leave one unassigned and infer a latch.
  always_comb begin
    head_valid = (count_q != 2'd0);
    stall      = (age_q == AGE_MAX);
    ready      = (count_q != 2'd2);
    push       = bus.lu_resp_valid && ready && (bus.lu_resp_rd != 5'd0);
    pop        = 1'b0;
    we         = 1'b0;
    idx        = 5'd0;
    wdata      = '0;

    if (stall && head_valid) begin
      pop = 1'b1;
    end else if (bus.pipe_wb_valid && (bus.pipe_wb_rd != 5'd0)) begin
      we    = 1'b1;
      idx   = bus.pipe_wb_rd;
      wdata = bus.pipe_wb_data;
    end else if (head_valid) begin
      pop = 1'b1;
    end

    // Buffered entries never carry rd=0, so a head pop is always a real write.
    if (pop) begin
      we    = 1'b1;
      idx   = fifo_q[0].rd;
      wdata = fifo_q[0].data;
    end

    // The value being committed now is forwarded by the regfile, so its bit
    // must not stall decode this cycle.
    pending_eff = pending_q;
    if (pop) pending_eff[fifo_q[0].rd] = 1'b0;
    haz = ((bus.rs1_index != 5'd0) && pending_eff[bus.rs1_index]) ||
          ((bus.rs2_index != 5'd0) && pending_eff[bus.rs2_index]);

    fifo_d  = fifo_q;
    count_d = count_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      count_d   = count_q - 2'd1;
    end
    if (push) begin
      fifo_d[count_d[0]] = '{rd: bus.lu_resp_rd, data: bus.lu_resp_data};
      count_d            = count_d + 2'd1;
    end

    age_d = age_q;
    if (!head_valid || pop) age_d = 4'd0;
    else if (age_q != AGE_MAX) age_d = age_q + 4'd1;

    // Clear before set: a same-cycle issue to the committed rd keeps it pending.
    pending_d = pending_q;
    if (pop) pending_d[fifo_q[0].rd] = 1'b0;
    if (bus.lu_issue_valid && (bus.lu_issue_rd != 5'd0)) pending_d[bus.lu_issue_rd] = 1'b1;
  end

  assign bus.lu_resp_ready   = ready;
  assign bus.pipe_stall      = stall;
  assign bus.hazard_stall    = haz;
  assign bus.rf_write_enable = we;
  assign bus.rf_rd_index     = idx;
  assign bus.rf_write_data   = wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      age_q     <= 4'd0;
      pending_q <= '0;
    end else begin
      count_q   <= count_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: the payload storage has no reset; count_q decides which entries are
  // live, so clearing it is enough to discard buffered results.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a queue-based reference model of the write-side rules.
module tb_writeback_arbiter;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  writeback_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t     mq[$];
  int       m_age  = 0;
  bit [31:0] m_pend = '0;

  logic          e_ready, e_pstall, e_haz, e_we, e_pop;
  logic [4:0]    e_idx;
  logic [DW-1:0] e_data;

  function automatic void model_eval();
    bit [31:0] eff;
    e_ready  = (mq.size() < 2);
    e_pstall = (m_age == MW);
    e_pop = 1'b0; e_we = 1'b0; e_idx = '0; e_data = '0;
    if (e_pstall && mq.size() > 0) e_pop = 1'b1;
    else if (bus.pipe_wb_valid && bus.pipe_wb_rd != 0) begin
      e_we = 1'b1; e_idx = bus.pipe_wb_rd; e_data = bus.pipe_wb_data;
    end else if (mq.size() > 0) e_pop = 1'b1;
    if (e_pop) begin
      e_we = 1'b1; e_idx = mq[0].rd; e_data = mq[0].data;
    end
    eff = m_pend;
    if (e_pop) eff[mq[0].rd] = 1'b0;
    e_haz = (bus.rs1_index != 0 && eff[bus.rs1_index]) ||
            (bus.rs2_index != 0 && eff[bus.rs2_index]);
  endfunction

  function automatic void model_advance();
    bit was_empty;
    if (rst) begin
      mq.delete(); m_age = 0; m_pend = '0;
      return;
    end
    was_empty = (mq.size() == 0);
    if (e_pop) begin
      m_pend[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (bus.lu_issue_valid && bus.lu_issue_rd != 0) m_pend[bus.lu_issue_rd] = 1'b1;
    if (bus.lu_resp_valid && e_ready && bus.lu_resp_rd != 0)
      mq.push_back('{rd: bus.lu_resp_rd, data: bus.lu_resp_data});
    if (was_empty || e_pop) m_age = 0;
    else if (m_age < MW) m_age++;
  endfunction

  task automatic idle();
    bus.pipe_wb_valid = 0; bus.pipe_wb_rd = 0; bus.pipe_wb_data = 0;
    bus.lu_issue_valid = 0; bus.lu_issue_rd = 0;
    bus.lu_resp_valid = 0; bus.lu_resp_rd = 0; bus.lu_resp_data = 0;
    bus.rs1_index = 0; bus.rs2_index = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clock();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (2) begin sample(); clock(); end
    rst = 0;
    sample();
    checks++; if (bus.lu_resp_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.lu_resp_ready); else passed++;
    checks++; if (bus.rf_write_enable !== 1'b0) $display("FAIL reset_we got=%b want=0", bus.rf_write_enable); else passed++;
    checks++; if (bus.hazard_stall !== 1'b0) $display("FAIL reset_haz got=%b want=0", bus.hazard_stall); else passed++;
    checks++; if (bus.pipe_stall !== 1'b0) $display("FAIL reset_pstall got=%b want=0", bus.pipe_stall); else passed++;
    checks++; if ({bus.rf_rd_index, bus.rf_write_data} !== '0)
      $display("FAIL reset_port got=%0d/%h want=0/0", bus.rf_rd_index, bus.rf_write_data); else passed++;
    clock();
  endtask

  task automatic test_pipe_write();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5; bus.pipe_wb_data = 32'hDEADBEEF;
    sample();
    checks++; if ({bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL pipe_write got=%b/%0d/%h want=1/5/deadbeef", bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data);
    else passed++;
    clock();
    bus.pipe_wb_rd = 0;
    sample();
    checks++; if (bus.rf_write_enable !== 1'b0) $display("FAIL pipe_x0 got=%b want=0", bus.rf_write_enable); else passed++;
    clock();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 7;
    sample(); clock();
    idle();
    bus.rs1_index = 7;
    bus.lu_resp_valid = 1; bus.lu_resp_rd = 7; bus.lu_resp_data = 32'h1234;
    sample();
    checks++; if (bus.hazard_stall !== 1'b1) $display("FAIL sb_pending got=%b want=1", bus.hazard_stall); else passed++;
    checks++; if (bus.lu_resp_ready !== 1'b1) $display("FAIL sb_accept got=%b want=1", bus.lu_resp_ready); else passed++;
    clock();
    bus.lu_resp_valid = 0;
    sample();
    checks++; if ({bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data, bus.hazard_stall} !== {1'b1, 5'd7, 32'h1234, 1'b0})
      $display("FAIL sb_commit got=%b/%0d/%h haz=%b want=1/7/1234 haz=0",
               bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data, bus.hazard_stall);
    else passed++;
    clock();
    sample();
    checks++; if ({bus.hazard_stall, bus.rf_write_enable} !== 2'b00)
      $display("FAIL sb_cleared got=haz%b we%b want=haz0 we0", bus.hazard_stall, bus.rf_write_enable); else passed++;
    clock();
  endtask

  task automatic test_buffer_full();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 3; bus.pipe_wb_data = 32'h33;
    bus.lu_resp_valid = 1; bus.lu_resp_rd = 10; bus.lu_resp_data = 32'hA0;
    sample();
    checks++; if (bus.lu_resp_ready !== 1'b1) $display("FAIL full_acc1 got=%b want=1", bus.lu_resp_ready); else passed++;
    clock();
    bus.lu_resp_rd = 11; bus.lu_resp_data = 32'hB0;
    sample();
    checks++; if (bus.lu_resp_ready !== 1'b1) $display("FAIL full_acc2 got=%b want=1", bus.lu_resp_ready); else passed++;
    clock();
    bus.lu_resp_rd = 12; bus.lu_resp_data = 32'hC0;
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++; if ({bus.lu_resp_ready, bus.rf_rd_index} !== {1'b0, 5'd3})
        $display("FAIL full_hold%0d got=rdy%b rd%0d want=rdy0 rd3", k, bus.lu_resp_ready, bus.rf_rd_index); else passed++;
      clock();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++; if ({bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data} !== {1'b1, 5'(10 + k), 32'(32'hA0 + 16 * k)})
        $display("FAIL full_drain%0d got=%b/%0d/%h want=1/%0d/%h", k, bus.rf_write_enable, bus.rf_rd_index,
                 bus.rf_write_data, 10 + k, 32'hA0 + 16 * k);
      else passed++;
      clock();
    end
    sample();
    checks++; if (bus.rf_write_enable !== 1'b0) $display("FAIL full_empty got=%b want=0", bus.rf_write_enable); else passed++;
    clock();
  endtask

  task automatic test_starvation();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 4; bus.pipe_wb_data = 32'h44;
    bus.lu_resp_valid = 1; bus.lu_resp_rd = 12; bus.lu_resp_data = 32'hC12;
    sample(); clock();
    bus.lu_resp_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      checks++; if ({bus.pipe_stall, bus.rf_rd_index} !== {1'b0, 5'd4})
        $display("FAIL starve_wait%0d got=ps%b rd%0d want=ps0 rd4", k, bus.pipe_stall, bus.rf_rd_index); else passed++;
      clock();
    end
    sample();
    checks++; if ({bus.pipe_stall, bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data} !== {1'b1, 1'b1, 5'd12, 32'hC12})
      $display("FAIL starve_drain got=ps%b %b/%0d/%h want=ps1 1/12/c12",
               bus.pipe_stall, bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data);
    else passed++;
    clock();
    sample();
    checks++; if ({bus.pipe_stall, bus.rf_rd_index} !== {1'b0, 5'd4})
      $display("FAIL starve_after got=ps%b rd%0d want=ps0 rd4", bus.pipe_stall, bus.rf_rd_index); else passed++;
    clock();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 3; bus.pipe_wb_data = 32'h1;
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 9;
    bus.lu_resp_valid = 1; bus.lu_resp_rd = 20; bus.lu_resp_data = 32'h20;
    sample(); clock();
    bus.lu_issue_valid = 0;
    bus.lu_resp_rd = 21; bus.lu_resp_data = 32'h21;
    bus.rs1_index = 9;
    sample();
    checks++; if (bus.hazard_stall !== 1'b1) $display("FAIL rmid_pre got=%b want=1", bus.hazard_stall); else passed++;
    clock();
    idle();
    rst = 1;
    sample(); clock();
    rst = 0;
    bus.rs1_index = 9;
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++; if ({bus.rf_write_enable, bus.lu_resp_ready, bus.hazard_stall} !== 3'b010)
        $display("FAIL rmid_post%0d got=we%b rdy%b haz%b want=we0 rdy1 haz0", k,
                 bus.rf_write_enable, bus.lu_resp_ready, bus.hazard_stall);
      else passed++;
      clock();
    end
    idle();
  endtask

  task automatic test_random();
    logic [DW+8:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.pipe_wb_valid  = $urandom_range(0, 1);
      bus.pipe_wb_rd     = 5'($urandom_range(0, 7));
      bus.pipe_wb_data   = $urandom;
      bus.lu_issue_valid = ($urandom_range(0, 3) == 0);
      bus.lu_issue_rd    = 5'($urandom_range(0, 7));
      bus.lu_resp_valid  = ($urandom_range(0, 4) < 2);
      bus.lu_resp_rd     = 5'($urandom_range(0, 7));
      bus.lu_resp_data   = $urandom;
      bus.rs1_index      = 5'($urandom_range(0, 7));
      bus.rs2_index      = 5'($urandom_range(0, 7));
      sample();
      if (!rst) begin
        got = {bus.lu_resp_ready, bus.pipe_stall, bus.hazard_stall, bus.rf_write_enable, bus.rf_rd_index, bus.rf_write_data};
        exp = {e_ready, e_pstall, e_haz, e_we, e_idx, e_data};
        checks++;
        if (got !== exp) $display("FAIL random cycle=%0d got=%h want=%h", n, got, exp);
        else passed++;
      end
      clock();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_scoreboard();
    test_buffer_full();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
